// File: rtl/trisc_pkg.sv
// Shared constants for the TRISC control sequencer: state encodings, control-word
// bit positions, opcode values and an opcode legality helper.
package trisc_pkg;

    localparam int CW = 15;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F0   = 4'd1,
        ST_F1   = 4'd2,
        ST_F2   = 4'd3,
        ST_DEC  = 4'd4,
        ST_MA   = 4'd5,
        ST_RD   = 4'd6,
        ST_LDW  = 4'd7,
        ST_ADDW = 4'd8,
        ST_SUBW = 4'd9,
        ST_STW  = 4'd10,
        ST_INC  = 4'd11,
        ST_CLR  = 4'd12,
        ST_JMP  = 4'd13,
        ST_HALT = 4'd14,
        ST_RSVD = 4'd15
    } state_e;

    // Control word bit positions.
    localparam int B_IR_OUT  = 14;
    localparam int B_PC_OUT  = 13;
    localparam int B_MAR_LD  = 12;
    localparam int B_MEM_RD  = 11;
    localparam int B_MDR_OUT = 10;
    localparam int B_IR_LD   = 9;
    localparam int B_PC_INC  = 8;
    localparam int B_ACC_LD  = 7;
    localparam int B_ACC_OUT = 6;
    localparam int B_ALU_ADD = 5;
    localparam int B_ALU_SUB = 4;
    localparam int B_ACC_INC = 3;
    localparam int B_ACC_CLR = 2;
    localparam int B_MEM_WR  = 1;
    localparam int B_PC_LD   = 0;

    localparam logic [3:0] OP_LDA = 4'h0;
    localparam logic [3:0] OP_STA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_INC = 4'h6;
    localparam logic [3:0] OP_CLR = 4'h7;
    localparam logic [3:0] OP_JMP = 4'h8;
    localparam logic [3:0] OP_JZ  = 4'h9;
    localparam logic [3:0] OP_HLT = 4'hF;

    function automatic logic opcode_legal(input logic [3:0] op);
        case (op)
            OP_LDA, OP_STA, OP_ADD, OP_SUB,
            OP_INC, OP_CLR, OP_JMP, OP_JZ, OP_HLT: opcode_legal = 1'b1;
            default:                               opcode_legal = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/trisc_seq_controller.sv
// TRISC control sequencer: fetch/decode/execute FSM with memory wait states,
// conditional branch, halt/resume and a sticky illegal-opcode trap.
module trisc_seq_controller
    import trisc_pkg::*;
#(
    parameter int OPW      = 4,
    parameter int WAIT_EN  = 1,
    parameter int AUTO_RUN = 0
) (
    input  logic           Clock,
    input  logic           Reset,
    input  logic           Run,
    input  logic [OPW-1:0] Opcode,
    input  logic           Zero,
    input  logic           MemReady,
    output logic [CW-1:0]  S,
    output logic [3:0]     state,
    output logic           Halted,
    output logic           IllegalOp
);

    localparam state_e RST_STATE = (AUTO_RUN != 0) ? ST_F0 : ST_IDLE;

    state_e      state_q, state_d;
    logic [3:0]  op_q, op_d;
    logic        illegal_q, illegal_d;
    logic [CW-1:0] s_w;

    logic        mem_ok;
    logic        hi_clear;
    logic [3:0]  op_lo;
    logic        op_legal;

    // With wait states disabled every memory access completes on its entry cycle.
    assign mem_ok   = (WAIT_EN == 0) ? 1'b1 : MemReady;
    assign hi_clear = ((Opcode >> 4) == '0);
    assign op_lo    = Opcode[3:0];
    assign op_legal = hi_clear && opcode_legal(op_lo);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q   <= RST_STATE;
            op_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        illegal_d = illegal_q;
        case (state_q)
            ST_IDLE: if (Run) state_d = ST_F0;
            ST_F0:   state_d = ST_F1;
            ST_F1:   if (mem_ok) state_d = ST_F2;
            ST_F2:   state_d = ST_DEC;
            ST_DEC: begin
                op_d = op_lo;
                if (!op_legal) begin
                    state_d   = ST_HALT;
                    illegal_d = 1'b1;
                end else begin
                    case (op_lo)
                        OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = ST_MA;
                        OP_INC:  state_d = ST_INC;
                        OP_CLR:  state_d = ST_CLR;
                        OP_JMP:  state_d = ST_JMP;
                        OP_JZ:   state_d = Zero ? ST_JMP : ST_F0;
                        OP_HLT:  state_d = ST_HALT;
                        default: begin
                            state_d   = ST_HALT;
                            illegal_d = 1'b1;
                        end
                    endcase
                end
            end
            // Execute states steer from the latched opcode, not the live IR field.
            ST_MA:   state_d = (op_q == OP_STA) ? ST_STW : ST_RD;
            ST_RD: begin
                if (mem_ok) begin
                    case (op_q)
                        OP_ADD:  state_d = ST_ADDW;
                        OP_SUB:  state_d = ST_SUBW;
                        default: state_d = ST_LDW;
                    endcase
                end
            end
            ST_LDW, ST_ADDW, ST_SUBW,
            ST_INC, ST_CLR, ST_JMP: state_d = ST_F0;
            ST_STW:  if (mem_ok) state_d = ST_F0;
            ST_HALT: if (Run && !illegal_q) state_d = ST_F0;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_w = '0;
        case (state_q)
            ST_F0: begin
                s_w[B_PC_OUT] = 1'b1;
                s_w[B_MAR_LD] = 1'b1;
            end
            ST_F1:   s_w[B_MEM_RD] = 1'b1;
            ST_F2: begin
                s_w[B_MDR_OUT] = 1'b1;
                s_w[B_IR_LD]   = 1'b1;
                s_w[B_PC_INC]  = 1'b1;
            end
            ST_MA: begin
                s_w[B_IR_OUT] = 1'b1;
                s_w[B_MAR_LD] = 1'b1;
            end
            ST_RD:   s_w[B_MEM_RD] = 1'b1;
            ST_LDW: begin
                s_w[B_MDR_OUT] = 1'b1;
                s_w[B_ACC_LD]  = 1'b1;
            end
            ST_ADDW: begin
                s_w[B_MDR_OUT] = 1'b1;
                s_w[B_ALU_ADD] = 1'b1;
                s_w[B_ACC_LD]  = 1'b1;
            end
            ST_SUBW: begin
                s_w[B_MDR_OUT] = 1'b1;
                s_w[B_ALU_SUB] = 1'b1;
                s_w[B_ACC_LD]  = 1'b1;
            end
            ST_STW: begin
                s_w[B_ACC_OUT] = 1'b1;
                s_w[B_MEM_WR]  = 1'b1;
            end
            ST_INC:  s_w[B_ACC_INC] = 1'b1;
            ST_CLR:  s_w[B_ACC_CLR] = 1'b1;
            ST_JMP: begin
                s_w[B_IR_OUT] = 1'b1;
                s_w[B_PC_LD]  = 1'b1;
            end
            default: s_w = '0;
        endcase
    end

    assign S         = s_w;
    assign state     = state_q;
    assign Halted    = (state_q == ST_HALT);
    assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_trisc_seq_controller.sv
// Self-checking bench for trisc_seq_controller: expected state/control-word pairs are
// queued as each cycle is driven and compared when the DUT advances.
module tb_trisc_seq_controller;

    localparam logic [3:0] IDLE = 4'd0,  F0 = 4'd1,  F1 = 4'd2,  F2 = 4'd3,
                           DEC = 4'd4,   MA = 4'd5,  RD = 4'd6,  LDW = 4'd7,
                           ADDW = 4'd8,  SUBW = 4'd9, STW = 4'd10, INC = 4'd11,
                           CLR = 4'd12,  JMP = 4'd13, HALT = 4'd14;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        Run;
    logic [3:0]  Opcode;
    logic        Zero;
    logic        MemReady;
    logic [14:0] S;
    logic [3:0]  state;
    logic        Halted;
    logic        IllegalOp;

    logic [18:0] exp_q[$];
    logic        exp_illegal = 1'b0;
    int          n_checks = 0;
    int          n_fail = 0;

    trisc_seq_controller #(.OPW(4), .WAIT_EN(1), .AUTO_RUN(0)) dut (
        .Clock(Clock), .Reset(Reset), .Run(Run), .Opcode(Opcode), .Zero(Zero),
        .MemReady(MemReady), .S(S), .state(state), .Halted(Halted), .IllegalOp(IllegalOp)
    );

    always #5 Clock = ~Clock;

    // Reference control word per state, written from the bit map.
    function automatic logic [14:0] s_ref(input logic [3:0] st);
        case (st)
            F0:      s_ref = 15'h3000;
            F1, RD:  s_ref = 15'h0800;
            F2:      s_ref = 15'h0700;
            MA:      s_ref = 15'h5000;
            LDW:     s_ref = 15'h0480;
            ADDW:    s_ref = 15'h04A0;
            SUBW:    s_ref = 15'h0490;
            STW:     s_ref = 15'h0042;
            INC:     s_ref = 15'h0008;
            CLR:     s_ref = 15'h0004;
            JMP:     s_ref = 15'h4001;
            default: s_ref = 15'h0000;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        logic [18:0] e;
        @(posedge Clock);
        #1;
        if (exp_q.size() != 1) begin
            check("queue_depth", exp_q.size(), 1);
        end else begin
            e = exp_q.pop_front();
            check("state", state, e[18:15]);
            check("S", S, e[14:0]);
            check("halted", Halted, e[18:15] == HALT);
            check("illegal", IllegalOp, exp_illegal);
        end
    endtask

    task automatic step(input logic [3:0] st);
        exp_q.push_back({st, s_ref(st)});
        tick();
    endtask

    task automatic mem_wait(input logic [3:0] st, input int w);
        for (int k = 0; k < w; k++) begin
            MemReady = 1'b0;
            step(st);
        end
        MemReady = 1'b1;
    endtask

    // Runs one legal non-HLT instruction from F0 back to F0.
    task automatic do_instr(input logic [3:0] op, input logic z, input int w_f1, input int w_mem);
        logic [3:0] nxt;
        Opcode   = op;
        Zero     = z;
        MemReady = 1'b1;
        step(F1);
        mem_wait(F1, w_f1);
        step(F2);
        step(DEC);
        case (op)
            4'h0, 4'h1, 4'h2, 4'h3: nxt = MA;
            4'h6: nxt = INC;
            4'h7: nxt = CLR;
            4'h8: nxt = JMP;
            default: nxt = z ? JMP : F0;
        endcase
        step(nxt);
        Opcode = 4'h4;
        Zero   = ~z;
        if (nxt == MA) begin
            if (op == 4'h1) begin
                step(STW);
                mem_wait(STW, w_mem);
            end else begin
                step(RD);
                mem_wait(RD, w_mem);
                step(op == 4'h0 ? LDW : (op == 4'h2 ? ADDW : SUBW));
            end
            step(F0);
        end else if (nxt != F0) begin
            step(F0);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_state"}, state, IDLE);
        check({tag, "_S"}, S, 0);
        check({tag, "_halted"}, Halted, 0);
        check({tag, "_illegal"}, IllegalOp, 0);
    endtask

    initial begin
        logic [3:0] op_tab[8];
        op_tab = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h6, 4'h7, 4'h8, 4'h9};
        Reset = 1'b1; Run = 1'b0; Opcode = 4'h0; Zero = 1'b0; MemReady = 1'b1;
        repeat (2) @(posedge Clock);
        #1;
        check_reset_state("reset");
        Reset = 1'b0;
        for (int i = 0; i < 10; i++) step(IDLE);
        Run = 1'b1;
        step(F0);
        Run = 1'b0;

        do_instr(4'h0, 1'b0, 0, 0);
        do_instr(4'h2, 1'b0, 2, 0);
        do_instr(4'h3, 1'b1, 0, 1);
        do_instr(4'h1, 1'b0, 0, 3);
        do_instr(4'h6, 1'b0, 0, 0);
        do_instr(4'h7, 1'b1, 1, 0);
        do_instr(4'h8, 1'b0, 0, 0);
        do_instr(4'h9, 1'b1, 0, 0);
        do_instr(4'h9, 1'b0, 0, 0);

        for (int i = 0; i < 20; i++)
            do_instr(op_tab[$urandom_range(0, 7)], 1'($urandom_range(0, 1)),
                     $urandom_range(0, 2), $urandom_range(0, 2));

        // HLT, hold, then resume on Run.
        Opcode = 4'hF;
        step(F1); step(F2); step(DEC); step(HALT);
        for (int i = 0; i < 3; i++) step(HALT);
        Run = 1'b1;
        step(F0);
        Run = 1'b0;

        // Illegal opcode traps; Run cannot leave HALT.
        Opcode = 4'h4;
        step(F1); step(F2); step(DEC);
        exp_illegal = 1'b1;
        step(HALT);
        Run = 1'b1;
        for (int i = 0; i < 3; i++) step(HALT);
        Run = 1'b0;
        #2 Reset = 1'b1;
        #1;
        exp_illegal = 1'b0;
        check_reset_state("trap_reset");
        @(posedge Clock);
        #1 Reset = 1'b0;
        Run = 1'b1;
        step(F0);
        Run = 1'b0;

        // Asynchronous reset while stalled in RD.
        Opcode = 4'h0;
        step(F1); step(F2); step(DEC); step(MA); step(RD);
        MemReady = 1'b0;
        step(RD);
        #2 Reset = 1'b1;
        #1;
        check_reset_state("rd_reset");
        @(posedge Clock);
        #1 Reset = 1'b0;
        MemReady = 1'b1;
        step(IDLE);
        Run = 1'b1;
        step(F0);
        Run = 1'b0;
        Opcode = 4'hF;
        step(F1); step(F2); step(DEC); step(HALT);
        Run = 1'b1;
        step(F0);
        Run = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time budget");
        $fatal(1, "timeout");
    end

endmodule
